// File: rtl/fp_int_acc_seq.sv
// fp_int_acc_seq
// Block-floating-point dot-product sequencer for the fp_int accumulator.
// One block of FP*INT partial products is buffered while its largest
// exponent is tracked. The elements are then issued one at a time to the
// external accumulator. Every issue carries exp_set = block max exponent,
// and the running sum is chained through acc_fixed_acc / acc_fixed_out.
//
// Optional feature macro: ACC_TIMEOUT_EN
//   defined   : WAIT is bounded by TIMEOUT_CYC cycles. A stuck element is
//               skipped and err goes high and stays high until rst.
//   undefined : WAIT is unbounded and err is constant 0.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   product handshake (ready only while loading)
//   in_sign/exp/mant    product fields; in_last closes the block
//   acc_start           one-cycle issue pulse to the accumulator
//   acc_sign/exp_in/fixed_in   element being issued (held ISSUE..WAIT)
//   acc_exp_set         block max exponent
//   acc_fixed_acc       running sum fed to the accumulator
//   acc_done            accumulator done (level; rising edge = completion)
//   acc_fixed_out       accumulator result
//   out_valid/out_ready block result handshake
//   out_exp, out_acc    block exponent and two's-complement sum
//   err                 sticky timeout flag
module fp_int_acc_seq #(
    parameter int DEPTH       = 16,
    parameter int EXP_W       = 5,
    parameter int MANT_W      = 14,
    parameter int ACC_W       = 32,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W-1:0] in_mant,
    input  logic              in_last,
    output logic              acc_start,
    output logic              acc_sign,
    output logic [EXP_W-1:0]  acc_exp_set,
    output logic [EXP_W-1:0]  acc_exp_in,
    output logic [MANT_W-1:0] acc_fixed_in,
    output logic [ACC_W-1:0]  acc_fixed_acc,
    input  logic              acc_done,
    input  logic [ACC_W-1:0]  acc_fixed_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [EXP_W-1:0]  out_exp,
    output logic [ACC_W-1:0]  out_acc,
    output logic              err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;                 // counts up to DEPTH inclusive
    localparam int DW = 1 + EXP_W + MANT_W;     // packed {sign, exp, mant}

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;
    localparam logic [2:0] S_OUT   = 3'd5;

    logic [2:0]       state_reg, state_next;
    logic [DW-1:0]    mem [DEPTH];
    logic [CW-1:0]    wr_cnt_reg, rd_cnt_reg;
    logic [EXP_W-1:0] max_exp_reg, max_exp_next;
    logic [ACC_W-1:0] sum_reg;
    logic             acc_done_d_reg;
    logic [DW-1:0]    issue_data_reg;

    logic             accept, block_close, done_edge, timeout, gap_more, issue_load;
    logic [AW-1:0]    rd_addr;
    logic [DW-1:0]    in_word;

    assign in_word      = {in_sign, in_exp, in_mant};
    assign accept       = in_valid && (state_reg == S_LOAD);
    // A full buffer closes the block exactly as an explicit in_last would.
    assign block_close  = accept && (in_last || (wr_cnt_reg == CW'(DEPTH - 1)));
    // Only a fresh rising edge counts. A done level still high from the
    // previous element is masked by acc_done_d_reg.
    assign done_edge    = (state_reg == S_WAIT) && acc_done && !acc_done_d_reg;
    assign gap_more     = (rd_cnt_reg < wr_cnt_reg);
    assign issue_load   = block_close || ((state_reg == S_GAP) && gap_more);
    // From LOAD the first issue always reads slot 0.
    assign rd_addr      = (state_reg == S_LOAD) ? '0 : rd_cnt_reg[AW-1:0];
    assign max_exp_next = (in_exp > max_exp_reg) ? in_exp : max_exp_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  state_next = S_LOAD;
            S_LOAD:  if (block_close) state_next = S_ISSUE;
            S_ISSUE: state_next = S_WAIT;
            S_WAIT:  if (done_edge || timeout) state_next = S_GAP;
            S_GAP:   state_next = gap_more ? S_ISSUE : S_OUT;
            S_OUT:   if (out_ready) state_next = S_LOAD;
            default: state_next = S_IDLE;
        endcase
    end

    // Element buffer: write-only port here, read port registered below.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_cnt_reg[AW-1:0]] <= in_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            wr_cnt_reg     <= '0;
            rd_cnt_reg     <= '0;
            max_exp_reg    <= '0;
            sum_reg        <= '0;
            acc_done_d_reg <= 1'b0;
            issue_data_reg <= '0;
        end else begin
            state_reg      <= state_next;
            acc_done_d_reg <= acc_done;

            if (accept) begin
                wr_cnt_reg  <= wr_cnt_reg + CW'(1);
                max_exp_reg <= max_exp_next;
            end

            if (block_close) begin
                sum_reg    <= '0;
                rd_cnt_reg <= '0;
            end

            if (done_edge) begin
                sum_reg    <= acc_fixed_out;
                rd_cnt_reg <= rd_cnt_reg + CW'(1);
            end else if (timeout) begin
                rd_cnt_reg <= rd_cnt_reg + CW'(1);
            end

            // A single-element block writes slot 0 in the same cycle that it
            // is read, so that element is taken straight from the input.
            if (issue_load) begin
                if ((state_reg == S_LOAD) && (wr_cnt_reg == '0)) begin
                    issue_data_reg <= in_word;
                end else begin
                    issue_data_reg <= mem[rd_addr];
                end
            end

            if ((state_reg == S_OUT) && out_ready) begin
                wr_cnt_reg  <= '0;
                max_exp_reg <= '0;
                sum_reg     <= '0;
            end
        end
    end

`ifdef ACC_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TW-1:0] wait_cnt_reg;
    logic          err_reg;

    // Fires on the TIMEOUT_CYC-th WAIT cycle if no completion arrived.
    assign timeout = (state_reg == S_WAIT) && !done_edge &&
                     (wait_cnt_reg == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_reg <= '0;
            err_reg      <= 1'b0;
        end else if (state_reg != S_WAIT) begin
            wait_cnt_reg <= '0;
        end else if (timeout) begin
            err_reg <= 1'b1;
        end else begin
            wait_cnt_reg <= wait_cnt_reg + TW'(1);
        end
    end

    assign err = err_reg;
`else
    assign timeout = 1'b0;
    // TIMEOUT_CYC has no effect in this build. This compare folds to 0.
    assign err     = (TIMEOUT_CYC < 0);
`endif

    assign in_ready      = (state_reg == S_LOAD);
    assign acc_start     = (state_reg == S_ISSUE);
    assign acc_sign      = issue_data_reg[DW-1];
    assign acc_exp_in    = issue_data_reg[MANT_W +: EXP_W];
    assign acc_fixed_in  = issue_data_reg[MANT_W-1:0];
    assign acc_exp_set   = max_exp_reg;
    assign acc_fixed_acc = sum_reg;
    assign out_valid     = (state_reg == S_OUT);
    assign out_exp       = max_exp_reg;
    assign out_acc       = sum_reg;

endmodule

// File: tb/tb_fp_int_acc_seq.sv
// Testbench for fp_int_acc_seq.
// A behavioural accumulator stub answers each acc_start after two cycles.
// The stub aligns the mantissa to exp_set, applies the sign, and adds
// acc_fixed_acc. The stub leaves acc_done high until the next issue, so the
// stale-done masking is exercised on every element. Expected block results
// are computed from the stimulus and queued. A negedge monitor pops the
// queue on each output handshake and compares.
module tb_fp_int_acc_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_sign, in_last;
    logic [4:0]  in_exp;
    logic [13:0] in_mant;
    logic        acc_start, acc_sign;
    logic [4:0]  acc_exp_set, acc_exp_in;
    logic [13:0] acc_fixed_in;
    logic [31:0] acc_fixed_acc;
    logic        acc_done;
    logic [31:0] acc_fixed_out;
    logic        out_valid, out_ready;
    logic [4:0]  out_exp;
    logic [31:0] out_acc;
    logic        err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fp_int_acc_seq dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
        .in_exp(in_exp), .in_mant(in_mant), .in_last(in_last),
        .acc_start(acc_start), .acc_sign(acc_sign), .acc_exp_set(acc_exp_set),
        .acc_exp_in(acc_exp_in), .acc_fixed_in(acc_fixed_in),
        .acc_fixed_acc(acc_fixed_acc), .acc_done(acc_done),
        .acc_fixed_out(acc_fixed_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_exp(out_exp), .out_acc(out_acc), .err(err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- accumulator stub ----------------
    logic       stall = 1'b0;
    logic [1:0] stub_cnt;

    function automatic logic [31:0] term(input logic s, input logic [4:0] es,
                                         input logic [4:0] ei, input logic [13:0] m);
        logic [31:0] mag;
        mag = {18'd0, m} >> (es - ei);
        return s ? -mag : mag;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            acc_done      <= 1'b0;
            stub_cnt      <= 2'd0;
            acc_fixed_out <= 32'd0;
        end else if (acc_start) begin
            acc_done      <= 1'b0;
            stub_cnt      <= 2'd1;
            acc_fixed_out <= acc_fixed_acc + term(acc_sign, acc_exp_set, acc_exp_in, acc_fixed_in);
        end else if (stub_cnt != 2'd0) begin
            stub_cnt <= stub_cnt - 2'd1;
            if (!stall) acc_done <= 1'b1;
        end
    end

    // ---------------- scoreboard ----------------
    int   exp_q[$];
    int   acc_q[$];
    bit   blk_s[$];
    int   blk_e[$];
    int   blk_m[$];
    int   exp_expect = 0;
    logic prev_start = 1'b0;

    always @(negedge clk) begin
        if (acc_start) begin
            check("start_width", {31'd0, prev_start}, 32'd0);
            check("exp_set", {27'd0, acc_exp_set}, exp_expect);
        end
        prev_start <= acc_start;
        if (out_valid && out_ready) begin
            if (acc_q.size() == 0) begin
                check("unexpected_out", 32'd1, 32'd0);
            end else begin
                int ea, ee;
                ea = acc_q.pop_front();
                ee = exp_q.pop_front();
                $display("block out: out_exp=%0d out_acc=%0h exp_acc=%0h", out_exp, out_acc, ea);
                check("out_acc", out_acc, ea);
                check("out_exp", {27'd0, out_exp}, ee);
            end
        end
    end

    task automatic elem(input bit s, input int e, input int m, input bit last);
        int n;
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = 5'(e);
        in_mant  = 14'(m);
        in_last  = last;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (blk_e.size() == 0) exp_expect = 0;
        if (e > exp_expect) exp_expect = e;
        blk_s.push_back(s);
        blk_e.push_back(e);
        blk_m.push_back(m);
    endtask

    task automatic close_block(input bit keep, input int skip);
        int mx, sum, t;
        mx  = 0;
        sum = 0;
        foreach (blk_e[i]) if (blk_e[i] > mx) mx = blk_e[i];
        foreach (blk_e[i]) begin
            if (i != skip) begin
                t = blk_m[i] >> (mx - blk_e[i]);
                sum = blk_s[i] ? sum - t : sum + t;
            end
        end
        if (keep) begin
            exp_q.push_back(mx);
            acc_q.push_back(sum);
        end
        blk_s.delete();
        blk_e.delete();
        blk_m.delete();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (acc_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check("drain_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v_acc;
        logic [4:0]  v_exp;
        int          n;

        rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0;
        in_mant = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_acc_start", {31'd0, acc_start}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_exp_set", {27'd0, acc_exp_set}, 32'd0);
        check("rst_fixed_acc", acc_fixed_acc, 32'd0);
        check("rst_fixed_in", {18'd0, acc_fixed_in}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Mixed exponents: 100>>2 + 40 - 10 = 55 at exponent 5.
        elem(0, 3, 100, 0);
        elem(0, 5, 40, 0);
        elem(1, 5, 10, 1);
        close_block(1, -1);
        drain();

        // A full buffer without in_last closes the block.
        for (int i = 0; i < 16; i++) elem(0, 4, 1, 0);
        @(negedge clk);
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        close_block(1, -1);
        drain();

        // Single negative element: -7 at exponent 0.
        elem(1, 0, 7, 1);
        close_block(1, -1);
        drain();

        // Output backpressure: the result must hold for 10 cycles.
        out_ready = 1'b0;
        elem(0, 2, 5, 0);
        elem(0, 1, 6, 1);
        close_block(1, -1);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("hold_out_valid_seen", {31'd0, out_valid}, 32'd1);
        v_acc = out_acc;
        v_exp = out_exp;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_acc", out_acc, v_acc);
            check("hold_exp", {27'd0, out_exp}, {27'd0, v_exp});
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain();

        // Reset while the first element is in WAIT.
        elem(0, 3, 9, 0);
        elem(0, 3, 9, 1);
        n = 0;
        @(negedge clk);
        while (!acc_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst_blk_issue_seen", {31'd0, acc_start}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_acc_start", {31'd0, acc_start}, 32'd0);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        close_block(0, -1);
        elem(0, 6, 64, 0);
        elem(1, 4, 64, 1);
        close_block(1, -1);
        drain();
        repeat (20) @(negedge clk);

`ifdef ACC_TIMEOUT_EN
        // The first element never completes. It is skipped, err sets, and
        // the second element still lands in the sum.
        stall = 1'b1;
        elem(0, 1, 3, 0);
        elem(0, 1, 5, 1);
        close_block(1, 0);
        n = 0;
        @(negedge clk);
        while (!acc_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        @(negedge clk);
        n++;
        while (!err && n < 40) begin
            @(negedge clk);
            n++;
        end
        stall = 1'b0;
        check("timeout_err", {31'd0, err}, 32'd1);
        check("timeout_cycles", n, 32'd16);
        drain();
        check("err_sticky", {31'd0, err}, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
